// File: rtl/pc_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg: shared op encoding, default sizes and sp-width helper for the PC unit.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pc_pkg;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_INC    = 3'd1,
    OP_BRANCH = 3'd2,
    OP_LOAD   = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } pc_op_t;

  localparam int unsigned C_DEF_ADDR_W      = 6;
  localparam int unsigned C_DEF_STACK_DEPTH = 4;

  // Occupancy counts 0..depth inclusive, so one bit more than the index.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_lifo.sv
// ----------------------------------------------------------------------------
// pc_lifo: register-array return-address LIFO; push/pop are ignored when full/empty.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_lifo
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = C_DEF_ADDR_W,
  parameter int unsigned STACK_DEPTH = C_DEF_STACK_DEPTH,
  localparam int unsigned SP_W       = sp_width(STACK_DEPTH),
  localparam int unsigned IDX_W      = $clog2(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] din_i,
  output logic [ADDR_W-1:0] top_o,
  output logic [SP_W-1:0]   sp_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_d;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_full;
  logic              w_empty;

  assign w_full   = (sp_q == SP_W'(STACK_DEPTH));
  assign w_empty  = (sp_q == '0);
  // When not full the low bits of sp address the next free slot directly.
  assign w_wr_idx = sp_q[IDX_W-1:0];
  assign w_rd_idx = w_wr_idx - IDX_W'(1);

  always_comb begin
    sp_d = sp_q;
    if (push_i && !w_full) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop_i && !w_empty) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !w_full) begin
      mem_q[w_wr_idx] <= din_i;
    end
  end

  assign top_o   = mem_q[w_rd_idx];
  assign sp_o    = sp_q;
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule

`default_nettype wire

// File: rtl/pc_stack_unit.sv
// ----------------------------------------------------------------------------
// pc_stack_unit: program counter with branch, call/return LIFO and stack flags.
// Optional macro PC_TRAP_EN redirects stack faults to TRAP_VEC with a trap pulse.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = C_DEF_ADDR_W,
  parameter int unsigned       STACK_DEPTH = C_DEF_STACK_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = '1,
  localparam int unsigned      SP_W        = sp_width(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadPC,
  input  logic              incPC,
  input  logic              branch,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] address,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] execadd,
  output logic [SP_W-1:0]   sp,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err,
  output logic              trap
);

  pc_op_t            w_op;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              err_q;
  logic              err_d;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_br;
  logic [ADDR_W-1:0] w_fault_pc;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_fault;

  always_comb begin
    w_op = OP_NONE;
    if (ret) begin
      w_op = OP_RET;
    end else if (call) begin
      w_op = OP_CALL;
    end else if (loadPC) begin
      w_op = OP_LOAD;
    end else if (branch) begin
      w_op = OP_BRANCH;
    end else if (incPC) begin
      w_op = OP_INC;
    end
  end

  // Plain ADDR_W-bit adds give the required modulo wrap and signed offset.
  assign w_pc_inc = pc_q + ADDR_W'(1);
  assign w_pc_br  = pc_q + offset;

  assign w_push  = (w_op == OP_CALL) && !w_full;
  assign w_pop   = (w_op == OP_RET)  && !w_empty;
  assign w_fault = ((w_op == OP_CALL) && w_full) || ((w_op == OP_RET) && w_empty);

`ifdef PC_TRAP_EN
  assign w_fault_pc = TRAP_VEC;
`else
  assign w_fault_pc = w_pc_inc;
`endif

  always_comb begin
    pc_d = pc_q;
    case (w_op)
      OP_INC:    pc_d = w_pc_inc;
      OP_BRANCH: pc_d = w_pc_br;
      OP_LOAD:   pc_d = address;
      OP_CALL:   pc_d = w_full  ? w_fault_pc : address;
      OP_RET:    pc_d = w_empty ? w_fault_pc : w_top;
      default:   pc_d = pc_q;
    endcase
  end

  assign err_d = err_q | w_fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

`ifdef PC_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= w_fault;
    end
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  pc_lifo #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_pc_inc),
    .top_o   (w_top),
    .sp_o    (sp),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign execadd     = pc_q;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign stack_err   = err_q;

endmodule

`default_nettype wire
